// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Register-file write-back arbiter. ALU results get priority;
//               load returns queue in a FIFO and are force-drained after
//               STARVE consecutive ALU wins. Exposes a pending-write
//               scoreboard query for hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int DSIZE  = 16,
  parameter int RSIZE  = 4,
  parameter int DEPTH  = 4,
  parameter int STARVE = 3
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [RSIZE-1:0]         alu_addr,
  input  logic [DSIZE-1:0]         alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [RSIZE-1:0]         mem_addr,
  input  logic [DSIZE-1:0]         mem_data,
  output logic                     Wen,
  output logic [RSIZE-1:0]         WAddr,
  output logic [DSIZE-1:0]         WData,
  input  logic [RSIZE-1:0]         q_addr,
  output logic                     q_pending,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE + 1);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             wen_q, wen_d;
  logic [RSIZE-1:0] waddr_q, waddr_d;
  logic [DSIZE-1:0] wdata_q, wdata_d;
  logic [RSIZE-1:0] fifo_addr_q [DEPTH];
  logic [DSIZE-1:0] fifo_data_q [DEPTH];

  logic             fifo_empty, forced, alu_win, pop, push;
  logic [RSIZE-1:0] win_addr;
  logic [DSIZE-1:0] win_data;
  logic [AW-1:0]    offs;
  logic             fifo_hit;

  // Winner selection, FIFO bookkeeping and next write-port values.
  always_comb begin
    fifo_empty = (count_q == '0);
    mem_ready  = (count_q != CW'(DEPTH));
    forced     = !fifo_empty && (starve_q == SW'(STARVE));
    alu_ready  = !forced;
    alu_win    = alu_valid && !forced;
    pop        = !fifo_empty && !alu_win;
    push       = mem_valid && mem_ready;

    win_addr = alu_win ? alu_addr : fifo_addr_q[rd_ptr_q];
    win_data = alu_win ? alu_data : fifo_data_q[rd_ptr_q];

    // Address 0 is a hardwired-zero register: consume the winner, no write.
    wen_d   = (alu_win || pop) && (win_addr != '0);
    waddr_d = wen_d ? win_addr : waddr_q;
    wdata_d = wen_d ? win_data : wdata_q;

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    // Starvation counts only ALU wins that leave queued loads waiting.
    starve_d = starve_q;
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (alu_win && (starve_q != SW'(STARVE))) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Scoreboard: any live FIFO entry or the write in the output register.
  always_comb begin
    fifo_hit = 1'b0;
    offs     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = AW'(i) - rd_ptr_q;
      if (({1'b0, offs} < count_q) && (fifo_addr_q[i] == q_addr)) begin
        fifo_hit = 1'b1;
      end
    end
    q_pending = (q_addr != '0) && (fifo_hit || (wen_q && (waddr_q == q_addr)));
  end

  // All state; reset discards queued loads and clears the write port.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      if (push) begin
        fifo_addr_q[wr_ptr_q] <= mem_addr;
        fifo_data_q[wr_ptr_q] <= mem_data;
      end
    end
  end

  assign Wen        = wen_q;
  assign WAddr      = waddr_q;
  assign WData      = wdata_q;
  assign fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Directed scenarios plus randomized traffic for wb_arbiter,
//               checked against a queue-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

  localparam int DSIZE = 16, RSIZE = 4, DEPTH = 4, STARVE = 3;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        alu_valid, alu_ready, mem_valid, mem_ready, Wen, q_pending;
  logic [3:0]  alu_addr, mem_addr, WAddr, q_addr;
  logic [15:0] alu_data, mem_data, WData;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [3:0]  mq_a [$];
  logic [15:0] mq_d [$];
  int          m_starve;
  logic        m_wen;
  logic [3:0]  m_waddr;
  logic [15:0] m_wdata;

  wb_arbiter #(.DSIZE(DSIZE), .RSIZE(RSIZE), .DEPTH(DEPTH), .STARVE(STARVE)) dut (
    .Clock(Clock), .Reset(Reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .Wen(Wen), .WAddr(WAddr), .WData(WData),
    .q_addr(q_addr), .q_pending(q_pending), .fifo_count(fifo_count)
  );

  always #5 Clock = ~Clock;

  task automatic model_reset();
    mq_a.delete();
    mq_d.delete();
    m_starve = 0;
    m_wen    = 1'b0;
    m_waddr  = '0;
    m_wdata  = '0;
  endtask

  // One rising edge of the model, from the arbitration rules.
  task automatic model_edge();
    int          sz;
    bit          ne, forced, aw, pop, push;
    logic [3:0]  wa;
    logic [15:0] wd;
    sz     = mq_a.size();
    ne     = (sz > 0);
    forced = ne && (m_starve == STARVE);
    aw     = alu_valid && !forced;
    pop    = ne && !aw;
    push   = mem_valid && (sz != DEPTH);
    wa = '0;
    wd = '0;
    if (aw) begin
      wa = alu_addr; wd = alu_data;
    end else if (pop) begin
      wa = mq_a[0]; wd = mq_d[0];
    end
    if (aw || pop) begin
      m_wen = (wa != 0);
      if (wa != 0) begin
        m_waddr = wa; m_wdata = wd;
      end
    end else begin
      m_wen = 1'b0;
    end
    if (pop || !ne) m_starve = 0;
    else if (m_starve < STARVE) m_starve = m_starve + 1;
    if (pop) begin
      void'(mq_a.pop_front());
      void'(mq_d.pop_front());
    end
    if (push) begin
      mq_a.push_back(mem_addr);
      mq_d.push_back(mem_data);
    end
  endtask

  function automatic bit model_pending(logic [3:0] qa);
    if (qa == 0) return 1'b0;
    foreach (mq_a[i]) if (mq_a[i] == qa) return 1'b1;
    return m_wen && (m_waddr == qa);
  endfunction

  task automatic set_in(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                        input logic mv, input logic [3:0] ma, input logic [15:0] md);
    @(negedge Clock);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    #1;
  endtask

  task automatic tick();
    @(posedge Clock);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0; q_addr = 4'd5;
    alu_valid = 0; alu_addr = 0; alu_data = 0; mem_valid = 0; mem_addr = 0; mem_data = 0;
    repeat (2) @(posedge Clock);
    #1;
    n_checks++; if (Wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %0b want 0", Wen); end
    n_checks++; if (WAddr !== 4'd0 || WData !== 16'd0) begin n_fail++; $display("FAIL reset_wport: got %h/%h want 0/0", WAddr, WData); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b%0b want 11", mem_ready, alu_ready); end
    n_checks++; if (q_pending !== 1'b0) begin n_fail++; $display("FAIL reset_qpend: got %0b want 0", q_pending); end
    @(negedge Clock);
    Reset = 1'b1;
    model_reset();
  endtask

  task automatic test_alu_only();
    set_in(1, 4'd3, 16'h1234, 0, 0, 0);
    tick();
    n_checks++; if (Wen !== 1'b1 || WAddr !== 4'd3 || WData !== 16'h1234) begin n_fail++; $display("FAIL alu_write: got %0b/%h/%h want 1/3/1234", Wen, WAddr, WData); end
    set_in(0, 0, 0, 0, 0, 0);
    tick();
    n_checks++; if (Wen !== 1'b0 || WAddr !== 4'd3) begin n_fail++; $display("FAIL alu_idle: got %0b/%h want 0/3", Wen, WAddr); end
  endtask

  task automatic test_load_only();
    set_in(0, 0, 0, 1, 4'd5, 16'hBEEF);
    tick();
    n_checks++; if (fifo_count !== 3'd1 || Wen !== 1'b0) begin n_fail++; $display("FAIL load_push: got cnt %0d wen %0b want 1/0", fifo_count, Wen); end
    q_addr = 4'd5;
    set_in(0, 0, 0, 0, 0, 0);
    n_checks++; if (q_pending !== 1'b1) begin n_fail++; $display("FAIL load_qpend: got %0b want 1", q_pending); end
    tick();
    n_checks++; if (Wen !== 1'b1 || WAddr !== 4'd5 || WData !== 16'hBEEF || fifo_count !== 3'd0) begin
      n_fail++; $display("FAIL load_write: got %0b/%h/%h cnt %0d want 1/5/beef cnt 0", Wen, WAddr, WData, fifo_count); end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      set_in(1, 4'(k + 1), 16'h0100 + 16'(k), 1, 4'(8 + k), 16'hA000 + 16'(k));
      tick();
    end
    set_in(1, 4'd1, 16'h0200, 1, 4'd12, 16'hAAAA);
    n_checks++; if (fifo_count !== 3'd4 || mem_ready !== 1'b0 || alu_ready !== 1'b0) begin
      n_fail++; $display("FAIL fill_full: got cnt %0d mr %0b ar %0b want 4/0/0", fifo_count, mem_ready, alu_ready); end
    tick();
    n_checks++; if (Wen !== 1'b1 || WAddr !== 4'd8 || WData !== 16'hA000 || fifo_count !== 3'd3) begin
      n_fail++; $display("FAIL fill_drain: got %0b/%h/%h cnt %0d want 1/8/a000 cnt 3", Wen, WAddr, WData, fifo_count); end
    n_checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready: got %0b%0b want 11", mem_ready, alu_ready); end
    for (int k = 1; k < 4; k++) begin
      set_in(0, 0, 0, 0, 0, 0);
      tick();
      n_checks++; if (Wen !== 1'b1 || WAddr !== 4'(8 + k) || WData !== 16'hA000 + 16'(k)) begin
        n_fail++; $display("FAIL fill_order%0d: got %0b/%h/%h want 1/%h/%h", k, Wen, WAddr, WData, 4'(8 + k), 16'hA000 + 16'(k)); end
    end
  endtask

  task automatic test_addr_zero();
    q_addr = 4'd0;
    set_in(1, 4'd0, 16'hFFFF, 0, 0, 0);
    n_checks++; if (alu_ready !== 1'b1 || q_pending !== 1'b0) begin n_fail++; $display("FAIL zero_ready: got ar %0b qp %0b want 1/0", alu_ready, q_pending); end
    tick();
    n_checks++; if (Wen !== 1'b0) begin n_fail++; $display("FAIL zero_wen: got %0b want 0", Wen); end
  endtask

  task automatic test_scoreboard();
    q_addr = 4'd7;
    set_in(1, 4'd1, 16'h0111, 1, 4'd7, 16'h7777);
    tick();
    for (int j = 0; j < 6; j++) begin
      set_in(1, 4'd1, 16'h0111, 0, 0, 0);
      n_checks++; if (q_pending !== (j <= 4)) begin n_fail++; $display("FAIL sb_pending%0d: got %0b want %0b", j, q_pending, (j <= 4)); end
      if (j == 3) begin
        n_checks++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL sb_force: got %0b want 0", alu_ready); end
      end
      tick();
      if (j == 3) begin
        n_checks++; if (Wen !== 1'b1 || WAddr !== 4'd7 || WData !== 16'h7777) begin n_fail++; $display("FAIL sb_write: got %0b/%h/%h want 1/7/7777", Wen, WAddr, WData); end
      end
    end
  endtask

  task automatic test_reset_mid();
    set_in(1, 4'd1, 16'h1111, 1, 4'd9, 16'h9999);
    tick();
    set_in(1, 4'd2, 16'h2222, 1, 4'd10, 16'hAAAA);
    tick();
    n_checks++; if (fifo_count !== 3'd2 || Wen !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got cnt %0d wen %0b want 2/1", fifo_count, Wen); end
    @(negedge Clock);
    alu_valid = 0; mem_valid = 0; q_addr = 4'd9;
    #2 Reset = 1'b0;
    #1;
    n_checks++; if (Wen !== 1'b0 || fifo_count !== 3'd0 || q_pending !== 1'b0 || mem_ready !== 1'b1) begin
      n_fail++; $display("FAIL rmid_async: got wen %0b cnt %0d qp %0b mr %0b want 0/0/0/1", Wen, fifo_count, q_pending, mem_ready); end
    @(negedge Clock);
    Reset = 1'b1;
    model_reset();
    for (int j = 0; j < 4; j++) begin
      set_in(0, 0, 0, 0, 0, 0);
      tick();
      n_checks++; if (Wen !== 1'b0) begin n_fail++; $display("FAIL rmid_post%0d: got wen %0b addr %h want wen 0", j, Wen, WAddr); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge Clock);
      alu_valid = ($urandom_range(0, 99) < 70);
      alu_addr  = 4'($urandom_range(0, 15));
      alu_data  = 16'($urandom);
      mem_valid = ($urandom_range(0, 99) < 55);
      mem_addr  = 4'($urandom_range(0, 15));
      mem_data  = 16'($urandom);
      q_addr    = 4'($urandom_range(0, 15));
      #1;
      n_checks++; if (mem_ready !== (mq_a.size() != DEPTH) || alu_ready !== !(m_starve == STARVE && mq_a.size() > 0)) begin
        n_fail++; $display("FAIL rnd_ready c%0d: got %0b%0b want %0b%0b", c, mem_ready, alu_ready, (mq_a.size() != DEPTH), !(m_starve == STARVE && mq_a.size() > 0)); end
      n_checks++; if (fifo_count !== 3'(mq_a.size())) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, fifo_count, mq_a.size()); end
      n_checks++; if (q_pending !== model_pending(q_addr)) begin n_fail++; $display("FAIL rnd_qpend c%0d: got %0b want %0b", c, q_pending, model_pending(q_addr)); end
      tick();
      n_checks++; if (Wen !== m_wen || WAddr !== m_waddr || WData !== m_wdata) begin
        n_fail++; $display("FAIL rnd_wport c%0d: got %0b/%h/%h want %0b/%h/%h", c, Wen, WAddr, WData, m_wen, m_waddr, m_wdata); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_alu_only();
    test_load_only();
    test_fill();
    test_addr_zero();
    test_scoreboard();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DSIZE, default 16, register data width.
REQ-002 SHALL have parameter RSIZE, default 4, register address width (16 registers).
REQ-003 SHALL have parameter DEPTH, default 4, load-return FIFO entries (power of 2).
REQ-004 SHALL have parameter STARVE, default 3, max consecutive ALU wins while FIFO non-empty.
REQ-005 SHALL have port Clock  in  1  single clock; all state on rising edge.
REQ-006 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port alu_valid  in  1  ALU result present this cycle.
REQ-008 SHALL have port alu_ready  out  1  ALU result accepted when alu_valid && alu_ready.
REQ-009 SHALL have port alu_addr  in  RSIZE  ALU destination register.
REQ-010 SHALL have port alu_data  in  DSIZE  ALU result.
REQ-011 SHALL have port mem_valid  in  1  load return present.
REQ-012 SHALL have port mem_ready  out  1  FIFO can accept a load return.
REQ-013 SHALL have port mem_addr  in  RSIZE  load destination register.
REQ-014 SHALL have port mem_data  in  DSIZE  loaded data.
REQ-015 SHALL have port Wen  out  1  registered write enable to register file.
REQ-016 SHALL have port WAddr  out  RSIZE  registered write address.
REQ-017 SHALL have port WData  out  DSIZE  registered write data.
REQ-018 SHALL have port q_addr  in  RSIZE  scoreboard query address.
REQ-019 SHALL have port q_pending  out  1  combinational: write to q_addr still in flight.
REQ-020 SHALL have port fifo_count  out  log2(DEPTH)+1  current FIFO occupancy.

Function
REQ-021 SHALL push {mem_addr, mem_data} into FIFO on rising edge when mem_valid && mem_ready.
REQ-022 SHALL drive mem_ready = (fifo_count != DEPTH); no same-cycle pass-through when full.
REQ-023 SHALL wrap read/write pointers modulo DEPTH; simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-024 SHALL, each cycle, select one winner: forced drain if starve count == STARVE and FIFO non-empty; else ALU if alu_valid; else FIFO head if non-empty; else none.
REQ-025 SHALL drive alu_ready = 0 only in forced-drain cycles; 1 otherwise.
REQ-026 SHALL register the winner into Wen/WAddr/WData at the rising edge; ALU latency = 1 cycle, load latency = 2 cycles minimum (push edge, then pop edge).
REQ-027 SHALL pop the FIFO head on the edge where it is the winner.
REQ-028 SHALL increment starve count on edges where ALU wins and FIFO is non-empty; SHALL clear it on any pop or when FIFO is empty; SHALL saturate at STARVE.
REQ-029 SHALL consume a winner with address 0 normally (accept/pop) but register Wen = 0 for it.
REQ-030 SHALL register Wen = 0 (WAddr/WData held) when no winner.
REQ-031 SHALL drive q_pending = 1 iff q_addr != 0 and q_addr matches any valid FIFO entry or (Wen && WAddr == q_addr).
REQ-032 SHALL preserve order of load returns (FIFO order) on the write port.

Reset
REQ-033 SHALL, while Reset = 0, asynchronously force Wen = 0, WAddr = 0, WData = 0, pointers = 0, fifo_count = 0, starve count = 0; mem_ready = 1, alu_ready = 1, q_pending = 0.
REQ-034 SHALL discard all FIFO contents on reset asserted mid-operation; no write issues from pre-reset entries.

Verification
REQ-035 ALU only: alu_valid=1, addr=3, data=0x1234 at edge N -> Wen=1, WAddr=3, WData=0x1234 after edge N; next idle cycle Wen=0.
REQ-036 Load only: mem push addr=5, data=0xBEEF at edge N -> fifo_count=1; Wen=1, WAddr=5 after edge N+1; fifo_count=0.
REQ-037 Fill: 4 loads pushed with alu_valid held 1 -> mem_ready=0 at count 4; after 3 ALU wins alu_ready=0 for one cycle and oldest load written; count 3, mem_ready=1.
REQ-038 Address 0: alu_valid with addr=0, data=0xFFFF -> alu_ready=1, Wen stays 0; q_addr=0 -> q_pending=0.
REQ-039 Scoreboard: load addr=7 queued behind ALU traffic, q_addr=7 -> q_pending=1 until edge after its write-back Wen cycle ends.
REQ-040 Reset mid-op: 2 entries queued, Reset=0 between edges -> Wen=0, fifo_count=0 immediately; after release no write to queued addresses.
